// File: rtl/down_counter_pkg.sv
// Shared state encoding and default sizing for the down-counter timer.
// Pure declarations: no logic, no latency.
package down_counter_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MAX_VAL = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// 8-bit event counter with synchronous clear, sticks at 255 instead of wrapping.
// One-cycle update latency; clear wins over increment, no backpressure.
module sat_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [7:0] o_cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_inc && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable down-counter timer with pause/abort and one-shot or periodic reload.
// tc is combinational on current state; q/done/busy update one edge after inputs; no backpressure.
module down_counter_timer
    import down_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MAX_VAL = DEF_MAX_VAL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             abort,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic [7:0]       wraps
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE_Q = WIDTH'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rl;

    logic w_at_zero;
    logic w_wrap;
    logic w_clr;

    assign w_at_zero = (r_q == '0);
    assign w_clr     = !abort && (r_state == ST_IDLE) && start;
    assign w_wrap    = !abort && (r_state == ST_RUN) && w_at_zero && auto_reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_q     <= MAX_Q;
            r_rl    <= MAX_Q;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_q     <= r_rl;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // q takes the old reload value even if a load lands on the same edge
                    if (load_en) begin
                        r_rl <= (load_val > MAX_Q) ? MAX_Q : load_val;
                    end
                    if (start) begin
                        r_q     <= r_rl;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_at_zero) begin
                        if (auto_reload) begin
                            r_q <= r_rl;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end else if (pause) begin
                        r_state <= ST_HOLD;
                    end else begin
                        r_q <= r_q - ONE_Q;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter u_wraps (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_clr),
        .i_inc (w_wrap),
        .o_cnt (wraps)
    );

    assign q    = r_q;
    assign busy = (r_state == ST_RUN) || (r_state == ST_HOLD);
    assign tc   = (r_state == ST_RUN) && w_at_zero && !abort;
    assign done = (r_state == ST_DONE) && !abort;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed scoreboard bench for down_counter_timer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_down_counter_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic       load_en = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic       auto_reload = 1'b0;
    logic [3:0] q;
    logic       busy;
    logic       tc;
    logic       done;
    logic [7:0] wraps;

    always #5 clk = ~clk;

    down_counter_timer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .abort       (abort),
        .load_en     (load_en),
        .load_val    (load_val),
        .auto_reload (auto_reload),
        .q           (q),
        .busy        (busy),
        .tc          (tc),
        .done        (done),
        .wraps       (wraps)
    );

    typedef struct packed {
        logic [3:0] q;
        logic       busy;
        logic       tc;
        logic       done;
        logic [7:0] wraps;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    string tag = "";

    // Push the expected outputs for the current cycle, then advance to just after the next edge.
    task automatic cyc(input int eq, input bit eb, input bit et, input bit ed, input int ew);
        obs_t e;
        e.q     = 4'(eq);
        e.busy  = eb;
        e.tc    = et;
        e.done  = ed;
        e.wraps = 8'(ew);
        exp_q.push_back(e);
        name_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin : monitor
        obs_t  e;
        obs_t  a;
        string n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {q, busy, tc, done, wraps};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got q=%0d busy=%0b tc=%0b done=%0b wraps=%0d, want q=%0d busy=%0b tc=%0b done=%0b wraps=%0d",
                         n, a.q, a.busy, a.tc, a.done, a.wraps, e.q, e.busy, e.tc, e.done, e.wraps);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        tag = "reset hold";
        cyc(11, 0, 0, 0, 0);
        rst_n = 1'b1;
        tag = "idle after reset";
        cyc(11, 0, 0, 0, 0);

        // One-shot countdown from the reset reload value
        start = 1'b1; auto_reload = 1'b0;
        tag = "oneshot start cycle";
        cyc(11, 0, 0, 0, 0);
        start = 1'b0;
        tag = "oneshot count";
        cyc(11, 1, 0, 0, 0);
        for (int k = 10; k >= 1; k--) cyc(k, 1, 0, 0, 0);
        tag = "oneshot tc";
        cyc(0, 1, 1, 0, 0);
        tag = "oneshot done";
        cyc(0, 0, 0, 1, 0);
        tag = "oneshot idle";
        cyc(0, 0, 0, 0, 0);

        // Clamped load then periodic mode
        load_en = 1'b1; load_val = 4'd15;
        tag = "load 15";
        cyc(0, 0, 0, 0, 0);
        load_en = 1'b0; start = 1'b1; auto_reload = 1'b1;
        tag = "periodic start cycle";
        cyc(0, 0, 0, 0, 0);
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tag = "periodic count";
            cyc(11, 1, 0, 0, w);
            for (int k = 10; k >= 1; k--) cyc(k, 1, 0, 0, w);
            tag = "periodic tc";
            cyc(0, 1, 1, 0, w);
        end
        tag = "wraps after 3 tc";
        cyc(11, 1, 0, 0, 3);
        for (int k = 10; k >= 1; k--) cyc(k, 1, 0, 0, 3);
        abort = 1'b1;
        tag = "abort masks tc";
        cyc(0, 1, 0, 0, 3);
        abort = 1'b0;
        tag = "abort to idle";
        cyc(11, 0, 0, 0, 3);

        // Pause/hold, ignored start and load while busy, abort mid-count
        auto_reload = 1'b0; start = 1'b1;
        tag = "pause test start";
        cyc(11, 0, 0, 0, 3);
        start = 1'b0;
        tag = "wraps cleared";
        cyc(11, 1, 0, 0, 0);
        tag = "pause test count";
        for (int k = 10; k >= 6; k--) begin
            start = (k == 8);
            cyc(k, 1, 0, 0, 0);
        end
        start = 1'b0;
        pause = 1'b1;
        tag = "pause at 5";
        cyc(5, 1, 0, 0, 0);
        tag = "hold";
        cyc(5, 1, 0, 0, 0);
        start = 1'b1; load_en = 1'b1; load_val = 4'd3;
        cyc(5, 1, 0, 0, 0);
        start = 1'b0; load_en = 1'b0;
        cyc(5, 1, 0, 0, 0);
        pause = 1'b0;
        tag = "hold release";
        cyc(5, 1, 0, 0, 0);
        tag = "back in run";
        cyc(5, 1, 0, 0, 0);
        tag = "resumed";
        cyc(4, 1, 0, 0, 0);
        abort = 1'b1;
        tag = "abort at 3";
        cyc(3, 1, 0, 0, 0);
        abort = 1'b0;
        tag = "abort reload ignores busy load";
        cyc(11, 0, 0, 0, 0);

        // Asynchronous reset mid-run
        start = 1'b1;
        tag = "reset test start";
        cyc(11, 0, 0, 0, 0);
        start = 1'b0;
        tag = "reset test count";
        cyc(11, 1, 0, 0, 0);
        for (int k = 10; k >= 8; k--) cyc(k, 1, 0, 0, 0);
        rst_n = 1'b0;
        tag = "async reset at 7";
        cyc(11, 0, 0, 0, 0);
        start = 1'b1;
        tag = "start held in reset";
        cyc(11, 0, 0, 0, 0);
        rst_n = 1'b1; start = 1'b0; load_en = 1'b1; load_val = 4'd0;
        tag = "first edge after reset";
        cyc(11, 0, 0, 0, 0);
        load_en = 1'b0;

        // Reload of zero: tc every cycle, wraps saturates
        start = 1'b1; auto_reload = 1'b1;
        tag = "zero reload start";
        cyc(11, 0, 0, 0, 0);
        start = 1'b0;
        tag = "zero reload run";
        for (int i = 0; i < 300; i++) cyc(0, 1, 1, 0, (i > 255) ? 255 : i);
        abort = 1'b1;
        tag = "zero reload abort";
        cyc(0, 1, 0, 0, 255);
        abort = 1'b0;
        tag = "zero reload idle";
        cyc(0, 0, 0, 0, 255);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
